regfile_write_scheduler: RTL and testbench

- Owns the single write port of the 32x32 general-purpose register file.
- After reset it zero-fills registers 1..31, one register per cycle.
- It then shares the write port between two write-back requesters: port A (pipeline write-back) and port B (multi-cycle unit / load return). It uses valid/ready handshakes and round-robin arbitration.
- Outputs are registered on posedge, so they are stable before the register file's negedge write.

---
 rtl/regfile_write_scheduler.sv | 121 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// Write-port owner for the general-purpose register file.
// Zero-fills registers 1..NUM_REGS-1 after reset, then arbitrates the single
// write port between two valid/ready requesters with round-robin priority.
// Write outputs are registered so they settle before the register file's
// negedge write.
module regfile_write_scheduler #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned NUM_REGS       = 32,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  a_valid,
   input  logic [ADDR_WIDTH-1:0] a_address,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [ADDR_WIDTH-1:0] b_address,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_address,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  clearing
);

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

   localparam state_t                RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(NUM_REGS - 1);

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] clear_count;
   logic                  last_grant_b;
   logic                  grant_a;
   logic                  grant_b;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= RESET_STATE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: leave the fill once the last register address has been issued
   always_comb begin
      state_next = state;
      if (state == S_CLEAR && clear_count == LAST_ADDR) begin
         state_next = S_RUN;
      end
   end

   // Round-robin grant; the port that did not win last time wins a contention.
   // Gated by reset so an in-flight handshake is voided asynchronously even
   // when the reset state is RUN.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == S_RUN && !reset) begin
         if (a_valid && (!b_valid || last_grant_b)) begin
            grant_a = 1'b1;
         end else if (b_valid) begin
            grant_b = 1'b1;
         end
      end
   end

   // Handshake and status outputs
   always_comb begin
      a_ready  = grant_a;
      b_ready  = grant_b;
      clearing = (state == S_CLEAR);
   end

   // Registered write port, fill counter and arbitration history
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clear_count   <= ADDR_WIDTH'(1);
         last_grant_b  <= 1'b1;
         write_enable  <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               write_enable  <= 1'b1;
               write_address <= clear_count;
               write_data    <= '0;
               clear_count   <= clear_count + ADDR_WIDTH'(1);
            end
            S_RUN: begin
               // Address 0 is accepted but never written
               if (grant_a) begin
                  write_enable  <= (a_address != '0);
                  write_address <= a_address;
                  write_data    <= a_data;
                  last_grant_b  <= 1'b0;
               end else if (grant_b) begin
                  write_enable  <= (b_address != '0);
                  write_address <= b_address;
                  write_data    <= b_data;
                  last_grant_b  <= 1'b1;
               end else begin
                  write_enable  <= 1'b0;
               end
            end
            default: begin
               write_enable  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: a register file model is
// written from the DUT's write port at negedge, and every write is matched
// against a queue of expected writes pushed when stimulus is driven.
module tb_regfile_write_scheduler;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          a_valid = 1'b0;
   logic [AW-1:0] a_address = '0;
   logic [DW-1:0] a_data = '0;
   logic          a_ready;
   logic          b_valid = 1'b0;
   logic [AW-1:0] b_address = '0;
   logic [DW-1:0] b_data = '0;
   logic          b_ready;
   logic          write_enable;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic          clearing;

   wr_t           sb[$];
   logic [DW-1:0] rf[NR];
   int            total = 0;
   int            bad = 0;
   bit            m_last_b = 1'b1;

   regfile_write_scheduler #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .NUM_REGS(NR),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .a_valid(a_valid),
      .a_address(a_address),
      .a_data(a_data),
      .a_ready(a_ready),
      .b_valid(b_valid),
      .b_address(b_address),
      .b_data(b_data),
      .b_ready(b_ready),
      .write_enable(write_enable),
      .write_address(write_address),
      .write_data(write_data),
      .clearing(clearing)
   );

   always #5 clock = ~clock;

   // Register file model and scoreboard check of every write
   always @(negedge clock) begin
      wr_t e;
      if (!reset && write_enable === 1'b1) begin
         rf[write_address] = write_data;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got=%0d/%h required=none", write_address, write_data);
         end else begin
            e = sb.pop_front();
            if (write_address !== e.addr || write_data !== e.data) begin
               bad++;
               $display("FAIL sb_write got=%0d/%h required=%0d/%h",
                        write_address, write_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic push_fill();
      for (int i = 1; i < NR; i++) sb.push_back('{addr: AW'(i), data: '0});
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      @(negedge clock);
      total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rst_we got=%b required=0", write_enable); end
      total++; if (write_address !== '0) begin bad++; $display("FAIL rst_wa got=%0d required=0", write_address); end
      total++; if (write_data !== '0) begin bad++; $display("FAIL rst_wd got=%h required=0", write_data); end
      total++; if (clearing !== 1'b1) begin bad++; $display("FAIL rst_clearing got=%b required=1", clearing); end
      total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         bad++; $display("FAIL rst_ready got=%b%b required=00", a_ready, b_ready);
      end
      sb.delete();
      m_last_b = 1'b1;
      reset = 1'b0;
   endtask

   task automatic test_clear();
      push_fill();
      for (int i = 0; i < NR - 1; i++) begin
         total++; if (clearing !== 1'b1) begin bad++; $display("FAIL clear_high cyc=%0d got=%b required=1", i, clearing); end
         @(negedge clock);
      end
      total++; if (clearing !== 1'b0) begin bad++; $display("FAIL clear_drop got=%b required=0", clearing); end
      @(negedge clock);
      total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL clear_idle_we got=%b required=0", write_enable); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL clear_drain got=%0d required=0", sb.size()); end
      #1;
      total++; if (rf[17] !== '0) begin bad++; $display("FAIL clear_r17 got=%h required=0", rf[17]); end
   endtask

   task automatic test_alternate();
      bit exp_a;
      a_valid = 1'b1; a_address = 5'd3; a_data = 32'h1111_1111;
      b_valid = 1'b1; b_address = 5'd4; b_data = 32'h2222_2222;
      for (int i = 0; i < 4; i++) begin
         #1;
         exp_a = m_last_b;
         total++; if (a_ready !== exp_a || b_ready !== !exp_a) begin
            bad++; $display("FAIL alt_grant cyc=%0d got=%b%b required=%b%b", i, a_ready, b_ready, exp_a, !exp_a);
         end
         if (exp_a) sb.push_back('{addr: 5'd3, data: 32'h1111_1111});
         else       sb.push_back('{addr: 5'd4, data: 32'h2222_2222});
         m_last_b = !exp_a;
         @(negedge clock);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clock);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL alt_drain got=%0d required=0", sb.size()); end
   endtask

   task automatic test_single_a();
      a_valid = 1'b1; a_address = 5'd5; a_data = 32'hDEAD_BEEF;
      #1;
      total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         bad++; $display("FAIL single_ready got=%b%b required=10", a_ready, b_ready);
      end
      sb.push_back('{addr: 5'd5, data: 32'hDEAD_BEEF});
      m_last_b = 1'b0;
      @(negedge clock);
      a_valid = 1'b0;
      @(negedge clock);
      total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL single_idle_we got=%b required=0", write_enable); end
      total++; if (write_address !== 5'd5 || write_data !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL single_hold got=%0d/%h required=5/deadbeef", write_address, write_data);
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL single_drain got=%0d required=0", sb.size()); end
      #1;
      total++; if (rf[5] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_r5 got=%h required=deadbeef", rf[5]); end
   endtask

   task automatic test_zero_addr();
      b_valid = 1'b1; b_address = 5'd0; b_data = 32'hFFFF_FFFF;
      #1;
      total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         bad++; $display("FAIL zero_ready got=%b%b required=01", a_ready, b_ready);
      end
      m_last_b = 1'b1;
      @(negedge clock);
      b_valid = 1'b0;
      total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL zero_we got=%b required=0", write_enable); end
      #1;
      total++; if (rf[0] !== '0) begin bad++; $display("FAIL zero_r0 got=%h required=0", rf[0]); end
      @(negedge clock);
      a_valid = 1'b1; a_address = 5'd9;  a_data = 32'h9999_9999;
      b_valid = 1'b1; b_address = 5'd10; b_data = 32'hAAAA_AAAA;
      #1;
      total++; if (a_ready !== m_last_b || b_ready !== !m_last_b) begin
         bad++; $display("FAIL zero_next_grant got=%b%b required=%b%b", a_ready, b_ready, m_last_b, !m_last_b);
      end
      sb.push_back('{addr: 5'd9, data: 32'h9999_9999});
      m_last_b = 1'b0;
      @(negedge clock);
      a_valid = 1'b0;
      #1;
      total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         bad++; $display("FAIL zero_b_after got=%b%b required=01", a_ready, b_ready);
      end
      sb.push_back('{addr: 5'd10, data: 32'hAAAA_AAAA});
      m_last_b = 1'b1;
      @(negedge clock);
      b_valid = 1'b0;
      @(negedge clock);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL zero_drain got=%0d required=0", sb.size()); end
   endtask

   task automatic test_clear_pending();
      #2 reset = 1'b1;
      sb.delete();
      m_last_b = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      a_valid = 1'b1; a_address = 5'd7; a_data = 32'h7777_7777;
      push_fill();
      for (int i = 0; i < NR - 1; i++) begin
         #1;
         total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL pend_blocked cyc=%0d got=%b required=0", i, a_ready); end
         @(negedge clock);
      end
      #1;
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL pend_accept got=%b required=1", a_ready); end
      sb.push_back('{addr: 5'd7, data: 32'h7777_7777});
      m_last_b = 1'b0;
      @(negedge clock);
      a_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL pend_drain got=%0d required=0", sb.size()); end
      #1;
      total++; if (rf[7] !== 32'h7777_7777) begin bad++; $display("FAIL pend_r7 got=%h required=77777777", rf[7]); end
   endtask

   task automatic test_reset_mid_clear();
      bit found;
      #2 reset = 1'b1;
      sb.delete();
      m_last_b = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      push_fill();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clock);
         if (write_enable === 1'b1 && write_address === 5'd12) found = 1'b1;
      end
      total++; if (!found) begin bad++; $display("FAIL mid_wait12 got=timeout required=addr12"); end
      #2 reset = 1'b1;
      #1;
      total++; if (write_enable !== 1'b0 || write_address !== '0 || write_data !== '0) begin
         bad++; $display("FAIL mid_async_out got=%b/%0d/%h required=0/0/0", write_enable, write_address, write_data);
      end
      total++; if (clearing !== 1'b1 || a_ready !== 1'b0) begin
         bad++; $display("FAIL mid_async_status got=%b%b required=10", clearing, a_ready);
      end
      sb.delete();
      push_fill();
      m_last_b = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < NR - 1; i++) begin
         total++; if (clearing !== 1'b1) begin bad++; $display("FAIL mid_refill cyc=%0d got=%b required=1", i, clearing); end
         @(negedge clock);
      end
      total++; if (clearing !== 1'b0) begin bad++; $display("FAIL mid_refill_end got=%b required=0", clearing); end
      @(negedge clock);
      total++; if (sb.size() != 0 || write_enable !== 1'b0) begin
         bad++; $display("FAIL mid_drain got=%0d/%b required=0/0", sb.size(), write_enable);
      end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) rf[i] = (i == 0) ? '0 : 32'hA5A5_A5A5;
      test_reset();
      test_clear();
      test_alternate();
      test_single_a();
      test_zero_addr();
      test_clear_pending();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
